// File: rtl/display_scan_controller_if.sv
// Signal bundle between the value datapath (master) and the display scan
// controller (slave). Digit data and masks in, board-pin drive and debug out.
interface display_scan_controller_if #(
  parameter int DIGITS = 4
);
  // No handshake: every signal is a level, sampled on each clk edge by the
  // receiver; values and masks may change in any cycle.
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_mask;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   blink_mask;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic [2:0]          digit_idx;
  logic                state_dbg;

  modport master (
    output value, dp_mask, blank_mask, blink_mask,
    input  an, seg, dp, digit_idx, state_dbg
  );

  modport slave (
    input  value, dp_mask, blank_mask, blink_mask,
    output an, seg, dp, digit_idx, state_dbg
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed common-anode 7-segment scanner: one digit per scan_lvl rise,
// with anode dead-time between digits, hex decode, decimal point, blank and blink.
module display_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_lvl,
  input  logic blink_lvl,
  display_scan_controller_if.slave bus
);

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [7:0]        DEAD_INIT = 8'(DEAD_CYCLES);
  localparam logic [2:0]        IDX_LAST  = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_OFF    = '1;

  state_e            state_q, state_d;
  logic              scan_q, scan_d;
  logic [7:0]        dead_cnt_q, dead_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              scan_rise;
  logic              dark;
  logic [31:0]       value_ext;
  logic [7:0]        dp_ext;
  logic [7:0]        blank_ext;
  logic [7:0]        blink_ext;
  logic [3:0]        nibble;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Inputs come from clk-domain divider registers, so no synchronizer.
  assign scan_rise = scan_lvl & ~scan_q;

  always_comb begin
    scan_d     = scan_lvl;
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    idx_d      = idx_q;
    if (scan_rise) begin
      state_d    = ST_DEAD;
      dead_cnt_d = DEAD_INIT;
      idx_d      = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else if (state_q == ST_DEAD) begin
      if (dead_cnt_q == 8'd0) begin
        state_d = ST_DRIVE;
      end else begin
        dead_cnt_d = dead_cnt_q - 8'd1;
      end
    end
  end

  // Outputs are decoded from next state and next index so the pins switch
  // on the same edge that registers the step.
  always_comb begin
    value_ext = 32'(bus.value);
    dp_ext    = 8'(bus.dp_mask);
    blank_ext = 8'(bus.blank_mask);
    blink_ext = 8'(bus.blink_mask);
    nibble    = value_ext[{idx_d, 2'b00} +: 4];
    dark      = blank_ext[idx_d] | (blink_ext[idx_d] & blink_lvl);
    an_d      = AN_OFF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    if (state_d == ST_DRIVE && !dark) begin
      an_d  = ~(AN_ONE << idx_d);
      seg_d = ~hex_decode(nibble);
      dp_d  = ~dp_ext[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DEAD;
      scan_q     <= 1'b0;
      dead_cnt_q <= DEAD_INIT;
      idx_q      <= 3'd0;
      an_q       <= AN_OFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      dead_cnt_q <= dead_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = idx_q;
  assign bus.state_dbg = (state_q == ST_DRIVE);

endmodule
